// File: rtl/uart_tx_scheduler_pkg.sv
// Shared types for the UART TX scheduler: FSM encoding, requester indices, idle byte.
// Also holds the round-robin index helpers used by the picker and the top.
package uart_tx_scheduler_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_WAIT_BUSY,
    ST_WAIT_DONE,
    ST_GAP
  } state_e;

  localparam logic [1:0] MOUSE = 2'd0;
  localparam logic [1:0] KEY   = 2'd1;
  localparam logic [1:0] CLICK = 2'd2;

  localparam logic [7:0] IDLE_BYTE = 8'hFF;

  function automatic logic [1:0] rr_next(input logic [1:0] idx);
    return (idx >= CLICK) ? MOUSE : idx + 2'd1;
  endfunction

  function automatic logic [1:0] onehot_to_idx(input logic [2:0] oh);
    if (oh[1]) return KEY;
    else if (oh[2]) return CLICK;
    else return MOUSE;
  endfunction

endpackage

// File: rtl/tx_rr_picker.sv
// Round-robin requester pick, purely combinational (zero latency, no backpressure).
// Search starts one past last_grant and wraps modulo 3.
module tx_rr_picker
  import uart_tx_scheduler_pkg::*;
(
  input  logic [2:0] req,
  input  logic [1:0] last_grant,
  output logic [2:0] pick
);

  logic [1:0] idx0;
  logic [1:0] idx1;
  logic [1:0] idx2;

  always_comb begin
    idx0 = rr_next(last_grant);
    idx1 = rr_next(idx0);
    idx2 = rr_next(idx1);
    pick = '0;
    if (req[idx0])      pick[idx0] = 1'b1;
    else if (req[idx1]) pick[idx1] = 1'b1;
    else if (req[idx2]) pick[idx2] = 1'b1;
  end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Credit-gated round-robin scheduler feeding a UART TX: grant at N+1, tx_start at N+2.
// Backpressure: no credits holds IDLE; tx_busy and the inter-frame gap stall further grants.
module uart_tx_scheduler
  import uart_tx_scheduler_pkg::*;
#(
  parameter int GAP_CYCLES   = 16,
  parameter int CREDIT_MAX   = 4,
  parameter int BUSY_TIMEOUT = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] req,
  input  logic [7:0] req_data0,
  input  logic [7:0] req_data1,
  input  logic [7:0] req_data2,
  input  logic       rx_ready,
  input  logic       tx_busy,
  output logic       tx_start,
  output logic [7:0] tx_data,
  output logic [2:0] grant,
  output logic [2:0] credits,
  output logic       tx_error
);

  localparam int GAP_W  = $clog2(GAP_CYCLES + 1);
  localparam int BUSY_W = $clog2(BUSY_TIMEOUT + 1);

  state_e            state_q, state_d;
  logic [2:0]        credits_q, credits_d;
  logic [1:0]        last_grant_q, last_grant_d;
  logic [GAP_W-1:0]  gap_q, gap_d;
  logic [BUSY_W-1:0] busy_cnt_q, busy_cnt_d;
  logic [7:0]        tx_data_q, tx_data_d;
  logic [2:0]        grant_q, grant_d;
  logic              tx_start_q, tx_start_d;
  logic              tx_error_q, tx_error_d;
  logic              run_q;
  logic              credit_dec;
  logic [2:0]        pick;

  tx_rr_picker u_picker (
    .req        (req),
    .last_grant (last_grant_q),
    .pick       (pick)
  );

  // Reset release is taken through one flop so nothing moves on the first edge after release.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) run_q <= 1'b0;
    else        run_q <= 1'b1;
  end

  always_comb begin
    state_d      = state_q;
    credits_d    = credits_q;
    last_grant_d = last_grant_q;
    gap_d        = gap_q;
    busy_cnt_d   = busy_cnt_q;
    tx_data_d    = tx_data_q;
    grant_d      = '0;
    tx_start_d   = 1'b0;
    tx_error_d   = 1'b0;
    credit_dec   = 1'b0;
    if (run_q) begin
      unique case (state_q)
        ST_IDLE: begin
          if (credits_q != 3'd0 && req != 3'b000) begin
            grant_d      = pick;
            last_grant_d = onehot_to_idx(pick);
            tx_data_d    = pick[0] ? req_data0 : (pick[1] ? req_data1 : req_data2);
            state_d      = ST_START;
          end
        end
        ST_START: begin
          tx_start_d = 1'b1;
          credit_dec = 1'b1;
          busy_cnt_d = '0;
          state_d    = ST_WAIT_BUSY;
        end
        ST_WAIT_BUSY: begin
          if (tx_busy) begin
            state_d = ST_WAIT_DONE;
          end else if (busy_cnt_q == BUSY_W'(BUSY_TIMEOUT - 1)) begin
            tx_error_d = 1'b1;
            gap_d      = GAP_W'(GAP_CYCLES - 1);
            state_d    = ST_GAP;
          end else begin
            busy_cnt_d = busy_cnt_q + 1'b1;
          end
        end
        ST_WAIT_DONE: begin
          if (!tx_busy) begin
            gap_d   = GAP_W'(GAP_CYCLES - 1);
            state_d = ST_GAP;
          end
        end
        ST_GAP: begin
          if (gap_q == '0) state_d = ST_IDLE;
          else             gap_d   = gap_q - 1'b1;
        end
        default: state_d = ST_IDLE;
      endcase

      // A credit returned in the same cycle as a START cancels the decrement, even at saturation.
      if (rx_ready && credit_dec)                     credits_d = credits_q;
      else if (rx_ready && credits_q < 3'(CREDIT_MAX)) credits_d = credits_q + 3'd1;
      else if (credit_dec)                            credits_d = credits_q - 3'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      credits_q    <= '0;
      last_grant_q <= CLICK;
      gap_q        <= '0;
      busy_cnt_q   <= '0;
      tx_data_q    <= IDLE_BYTE;
      grant_q      <= '0;
      tx_start_q   <= 1'b0;
      tx_error_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      credits_q    <= credits_d;
      last_grant_q <= last_grant_d;
      gap_q        <= gap_d;
      busy_cnt_q   <= busy_cnt_d;
      tx_data_q    <= tx_data_d;
      grant_q      <= grant_d;
      tx_start_q   <= tx_start_d;
      tx_error_q   <= tx_error_d;
    end
  end

  assign tx_start = tx_start_q;
  assign tx_data  = tx_data_q;
  assign grant    = grant_q;
  assign credits  = credits_q;
  assign tx_error = tx_error_q;

endmodule

// File: doc/uart_tx_scheduler.md
UART_TX_SCHEDULER -- requirements
Module: uart_tx_scheduler

Interface
REQ-001 Parameter GAP_CYCLES, default 16, is the number of idle clk cycles enforced between consecutive frames.
REQ-002 Parameter CREDIT_MAX, default 4, is the saturation limit of the PC flow-control credit counter.
REQ-003 Parameter BUSY_TIMEOUT, default 8, is the number of cycles to wait for tx_busy to rise after tx_start.
REQ-004 Port clk, input, 1 bit: the single clock; all state changes occur on its rising edge.
REQ-005 Port reset, input, 1 bit: asynchronous, active-low reset (reset=0 asserts).
REQ-006 Port req, input, 3 bits: level requests; bit0 is the mouse stream, bit1 is the keystroke stream, bit2 is the click/backspace stream.
REQ-007 Ports req_data0, req_data1 and req_data2, input, 8 bits each: the command byte offered by each requester.
REQ-008 Port rx_ready, input, 1 bit: a one-cycle pulse from the receiver granting one frame credit.
REQ-009 Port tx_busy, input, 1 bit: high while the UART transmitter is shifting a frame.
REQ-010 Port tx_start, output, 1 bit: a one-cycle transmit strobe.
REQ-011 Port tx_data, output, 8 bits: the byte presented to the transmitter.
REQ-012 Port grant, output, 3 bits: a one-hot, one-cycle pulse acknowledging the served requester.
REQ-013 Port credits, output, 3 bits: the current credit count.
REQ-014 Port tx_error, output, 1 bit: a one-cycle pulse raised on busy timeout.

Function
REQ-015 The FSM SHALL have the states IDLE, START, WAIT_BUSY, WAIT_DONE and GAP, with every output registered.
REQ-016 In IDLE with credits>0 and req!=0, the FSM SHALL select one requester by round-robin, latch its req_data into tx_data, pulse grant one cycle later and enter START.
REQ-017 Round-robin search SHALL start at index (last_grant+1) mod 3; after reset last_grant=2, so bit0 has first priority.
REQ-018 In START, tx_start SHALL be 1 for exactly one cycle, credits SHALL decrement by 1, and the FSM SHALL enter WAIT_BUSY.
REQ-019 In WAIT_BUSY, tx_busy=1 SHALL move the FSM to WAIT_DONE; after BUSY_TIMEOUT cycles without tx_busy, the block SHALL pulse tx_error and enter GAP.
REQ-020 In WAIT_DONE, tx_busy=0 SHALL load the gap counter with GAP_CYCLES-1 and move the FSM to GAP.
REQ-021 In GAP, the block SHALL count down to 0 and then enter IDLE; requests SHALL be ignored while in GAP.
REQ-022 tx_data SHALL hold its latched value from grant until the next grant, regardless of any changes on req_data.
REQ-023 Latency: with req sampled in IDLE at cycle N, grant SHALL be high at N+1 and tx_start SHALL be high at N+2.
REQ-024 rx_ready SHALL increment credits, saturating at CREDIT_MAX; further pulses at saturation SHALL be dropped.
REQ-025 If rx_ready and the START decrement occur in the same cycle, credits SHALL remain unchanged.
REQ-026 With credits=0, the FSM SHALL stay in IDLE and leave tx_start, grant and tx_data unchanged.
REQ-027 A requester that drops req before its grant SHALL NOT be served, and no pending flag SHALL be stored for it.
REQ-028 At most one grant and one tx_start SHALL occur per frame, and grant SHALL never have more than one bit set.

Reset
REQ-029 On reset=0, the block SHALL immediately force state=IDLE, credits=0, last_grant=2, gap counter=0, tx_data=8'hFF, and tx_start=grant=tx_error=0.
REQ-030 Reset asserted mid-frame SHALL abandon the frame and SHALL NOT restore the consumed credit.
REQ-031 Reset release SHALL be synchronized; the first state transition is permitted on the second rising edge after release.

Structure
REQ-032 A shared package SHALL hold the FSM state encoding, the requester index constants (MOUSE=0, KEY=1, CLICK=2) and the idle byte 8'hFF.
REQ-033 Round-robin selection SHALL be implemented in one combinational sub-module named tx_rr_picker (inputs req and last_grant; output a one-hot pick).
REQ-034 The credit counter and gap counter SHALL reside in the top module.

Verification
REQ-035 Scenario 1: reset, one rx_ready pulse, then req=3'b010 with req_data1=8'hC5 -> grant=3'b010 at N+1, tx_start at N+2 with tx_data=8'hC5, credits 1->0.
REQ-036 Scenario 2: three credits with req=3'b111 held -> grants in order 001, 010, 100, each separated by at least GAP_CYCLES after tx_busy falls.
REQ-037 Scenario 3: credits=0 with req=3'b001 held -> no tx_start for 100 cycles; one rx_ready pulse -> exactly one frame is sent.
REQ-038 Scenario 4: six rx_ready pulses with CREDIT_MAX=4 -> credits=4; then rx_ready coincident with START -> credits stays at 4.
REQ-039 Scenario 5: tx_busy tied to 0 -> tx_error pulses 8 cycles after tx_start, the FSM enters GAP and then returns to IDLE.
REQ-040 Scenario 6: reset asserted in WAIT_DONE -> outputs reach their reset values asynchronously, credits=0, and the next grant goes to bit0.
